arrayed_mem_wr_arbiter: RTL
===========================

Name: arrayed_mem_wr_arbiter

Overview:
Owns a DEPTH x WIDTH register array and shares its single write port among NUM_REQ requesters using round-robin arbitration with one write per cycle. A sequenced CLEAR operation zeroes the array one entry per cycle. The full array contents are exported flat as a wide output for downstream sinks. A saturating write counter is provided for observability.

Parameters:
NUM_REQ, 4, number of write requesters
DEPTH, 4, number of array entries
WIDTH, 2, bits per entry
ADDR_W, 2, entry address width; must satisfy 2**ADDR_W >= DEPTH
CNT_W, 8, width of the write counter

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk
req  input  NUM_REQ  per-requester write request; held until granted
wr_addr  input  NUM_REQ*ADDR_W  requester i's address in bits [i*ADDR_W +: ADDR_W]
wr_data  input  NUM_REQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  one-hot combinational grant; the write commits at the edge ending this cycle
clr_start  input  1  single-cycle pulse that starts a sequenced clear
busy  output  1  high while the CLEAR sequence runs
wr_cnt  output  CNT_W  number of committed requester writes, saturating
out  output  DEPTH*WIDTH  {mem[0], mem[1], ..., mem[DEPTH-1]}; entry 0 occupies the MSBs

Behaviour:
- Reset (rst_n=0 at posedge): all mem entries = 0, rr_ptr = 0, state = IDLE, clr_idx = 0, wr_cnt = 0. Outputs out = 0 and busy = 0 from the following cycle. gnt is forced to 0 combinationally while rst_n = 0.
- A reset asserted during CLEAR aborts the sequence. Post-reset state is identical to a normal reset.
- FSM has two states, IDLE and CLEAR. busy = (state == CLEAR), registered.
- IDLE, clr_start=1: go to CLEAR with clr_idx=0. gnt is all 0 in this cycle; clear has priority and any pending request waits.
- IDLE, clr_start=0: arbitrate.
  - Search req starting at index rr_ptr, ascending, modulo NUM_REQ. The first set bit i wins and gnt[i]=1.
  - At the posedge: mem[wr_addr_i] <= wr_data_i; rr_ptr <= (i+1) mod NUM_REQ; wr_cnt <= wr_cnt+1, saturating at all-ones.
  - No req set: gnt=0; rr_ptr, mem and wr_cnt are unchanged.
- Out-of-range address (wr_addr_i >= DEPTH): the grant is still issued and rr_ptr still advances. No array entry changes. wr_cnt is not incremented.
- CLEAR: each cycle mem[clr_idx] <= 0 and clr_idx increments. After the cycle with clr_idx = DEPTH-1, return to IDLE. CLEAR lasts exactly DEPTH cycles. gnt is all 0 and clr_start is ignored throughout. rr_ptr and wr_cnt are held.
- Latency:
  - Write: out reflects a granted write one cycle after the gnt cycle.
  - Clear: with clr_start in cycle N, busy is high in cycles N+1..N+DEPTH and the first grant is possible in cycle N+DEPTH+1. Entry k reads 0 on out from cycle N+2+k.
- Requester protocol: req, wr_addr and wr_data must stay stable until the cycle gnt[i]=1. req may be deasserted or re-raised with new data in the next cycle.
- Multiple requesters targeting the same address are serialised; the last granted one wins.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with random req -> gnt=0 during reset; afterwards out=8'h00, busy=0, wr_cnt=0.
- Single write: req=4'b0100, addr2=1, data2=2'b11 -> gnt=4'b0100 that cycle; next cycle out=8'b00_11_00_00, wr_cnt=1.
- Round-robin: all four req held with addr i, data 2'b01 -> gnt sequence 0001, 0010, 0100, 1000, 0001; after 4 grants out=8'h55; the 5th grant goes to requester 0.
- Pointer wrap: after a grant to requester 3, with req=4'b1001 -> next grant goes to requester 0, then requester 3.
- Clear with collision: out=8'hFF, then clr_start and req[1] together in the same cycle -> gnt=0, busy high for 4 cycles, out=8'h00 afterwards; req[1] granted in the first cycle after busy falls.
- Reset mid-clear, saturation and bad address:
  - rst_n=0 in the 2nd CLEAR cycle -> busy=0 and out=0 afterwards.
  - With CNT_W=2, 5 writes -> wr_cnt holds at 3.
  - A write with addr>=DEPTH (DEPTH=3) -> gnt issued; out and wr_cnt unchanged.

Source files
------------

// File: rtl/arrayed_mem_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arrayed_mem_wr_arbiter
// Description : DEPTH x WIDTH register array whose single write port is shared
//               by NUM_REQ round-robin requesters, with a sequenced clear.
// Revision    : 1.0 - initial release
// ============================================================================
module arrayed_mem_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 2,
   parameter int ADDR_W  = 2,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
   input  logic [NUM_REQ*WIDTH-1:0]  wr_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      clr_start,
   output logic                      busy,
   output logic [CNT_W-1:0]          wr_cnt,
   output logic [DEPTH*WIDTH-1:0]    out
);

   localparam int                PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_idx;
   logic [PTR_W-1:0]  r_rr_ptr;
   logic [PTR_W-1:0]  w_ptr_nxt;
   logic [CNT_W-1:0]  r_wr_cnt;
   logic [WIDTH-1:0]  r_mem [DEPTH];

   logic [NUM_REQ-1:0] w_gnt;
   logic               w_found;
   logic [ADDR_W-1:0]  w_win_addr;
   logic [WIDTH-1:0]   w_win_data;
   logic               w_wr_en;

   // Index of the k-th requester in search order, starting from the pointer
   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return PTR_W'(sum);
   endfunction

   always_comb begin
      w_gnt   = '0;
      w_found = 1'b0;
      if (rst_n && (r_state == ST_IDLE) && !clr_start) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[f_wrap(r_rr_ptr, k)]) begin
               w_found                   = 1'b1;
               w_gnt[f_wrap(r_rr_ptr, k)] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_win_addr = '0;
      w_win_data = '0;
      w_ptr_nxt  = r_rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_win_addr = wr_addr[i*ADDR_W +: ADDR_W];
            w_win_data = wr_data[i*WIDTH +: WIDTH];
            w_ptr_nxt  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   // A granted write to an address outside the array is dropped silently
   assign w_wr_en = w_found && ({1'b0, w_win_addr} < c_DEPTH);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (clr_start) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (r_clr_idx == c_LAST_IDX) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_clr_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR && r_clr_idx != c_LAST_IDX)
            r_clr_idx <= r_clr_idx + 1'b1;
         else
            r_clr_idx <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_found) r_rr_ptr <= w_ptr_nxt;
         if (w_wr_en && (r_wr_cnt != {CNT_W{1'b1}}))
            r_wr_cnt <= r_wr_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (!rst_n)
            r_mem[e] <= '0;
         else if (r_state == ST_CLEAR) begin
            if (r_clr_idx == ADDR_W'(e)) r_mem[e] <= '0;
         end else if (w_wr_en && (w_win_addr == ADDR_W'(e)))
            r_mem[e] <= w_win_data;
      end
   end

   assign gnt    = w_gnt;
   assign busy   = (r_state == ST_CLEAR);
   assign wr_cnt = r_wr_cnt;

   // Entry 0 lands in the most significant slice of the flat output
   generate
      for (genvar e = 0; e < DEPTH; e++) begin : g_out
         assign out[(DEPTH-1-e)*WIDTH +: WIDTH] = r_mem[e];
      end
   endgenerate

endmodule
`default_nettype wire
